// File: rtl/timer_host_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_host_sequencer_if                                              |
// | Register bus between the sequencer (master) and interval-timer slave |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface timer_host_sequencer_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_readdata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_readdata,
        output tmr_irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_host_sequencer                                                 |
// | Programs and services the interval-timer slave; TIMER_HOST_POLL_EN   |
// | replaces interrupt servicing with periodic status polling.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module timer_host_sequencer #(
    parameter int unsigned POLL_GAP = 8
) (
    input  wire         clk,
    input  wire         reset,
    input  wire         cfg_valid,
    output logic        cfg_ready,
    input  wire  [31:0] cfg_period,
    input  wire         cfg_continuous,
    input  wire         stop_req,
    input  wire         snap_req,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        tick,
    output logic [15:0] timeout_count,
    output logic        running,
    timer_host_sequencer_if.master tmr
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PROG_STOP  = 4'd1,
        S_PROG_PL    = 4'd2,
        S_PROG_PH    = 4'd3,
        S_PROG_START = 4'd4,
        S_RUN        = 4'd5,
        S_ACK        = 4'd6,
        S_STOP       = 4'd7,
        S_SNAP_W     = 4'd8,
        S_SNAP_RL    = 4'd9,
        S_SNAP_LC    = 4'd10,
        S_SNAP_RH    = 4'd11,
        S_SNAP_HC    = 4'd12,
        S_POLL_R     = 4'd13,
        S_POLL_C     = 4'd14
    } state_t;

    localparam logic [2:0]  c_addr_status = 3'd0;
    localparam logic [2:0]  c_addr_ctrl   = 3'd1;
    localparam logic [2:0]  c_addr_pl     = 3'd2;
    localparam logic [2:0]  c_addr_ph     = 3'd3;
    localparam logic [2:0]  c_addr_snl    = 3'd4;
    localparam logic [2:0]  c_addr_snh    = 3'd5;
    localparam logic [15:0] c_ctrl_stop   = 16'h0008;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        cont_q, cont_d;
    logic [15:0] count_q, count_d;
    logic        running_q, running_d;
    logic        tick_q, tick_d;
    logic        snap_valid_q, snap_valid_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic        snap_ret_run_q, snap_ret_run_d;
    logic        stop_pend_q, stop_pend_d;
    logic        snap_pend_q, snap_pend_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [15:0] wdata_q, wdata_d;

    logic w_irq;
    logic w_poll_due;
    logic w_stop;
    logic w_snap;
    logic w_cfg_ok;
    logic w_cfg_accept;

`ifdef TIMER_HOST_POLL_EN
    localparam logic c_ito = 1'b0;
    logic [7:0] gap_q, gap_d;
    logic       w_unused_irq;

    assign w_irq        = 1'b0;
    assign w_poll_due   = (gap_q == 8'(POLL_GAP - 1));
    assign w_unused_irq = tmr.tmr_irq;
`else
    localparam logic c_ito = 1'b1;
    logic [7:0] w_unused_poll_gap;

    assign w_irq             = tmr.tmr_irq;
    assign w_poll_due        = 1'b0;
    assign w_unused_poll_gap = 8'(POLL_GAP);
`endif

    // Requests seen this cycle merge with anything held from busy states.
    assign w_stop       = stop_pend_q | stop_req;
    assign w_snap       = snap_pend_q | snap_req;
    assign w_cfg_ok     = ((state_q == S_IDLE) && !w_snap) ||
                          ((state_q == S_RUN) && !w_irq && !w_stop && !w_snap);
    assign w_cfg_accept = cfg_valid && w_cfg_ok;

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        cont_d         = cont_q;
        count_d        = count_q;
        running_d      = running_q;
        tick_d         = 1'b0;
        snap_valid_d   = 1'b0;
        snap_value_d   = snap_value_q;
        snap_lo_d      = snap_lo_q;
        snap_ret_run_d = snap_ret_run_q;
        stop_pend_d    = w_stop;
        snap_pend_d    = w_snap;
`ifdef TIMER_HOST_POLL_EN
        gap_d          = 8'd0;
`endif

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (w_snap) begin
                    state_d        = S_SNAP_W;
                    snap_pend_d    = 1'b0;
                    snap_ret_run_d = 1'b0;
                end
            end
            S_RUN: begin
                if (w_irq) begin
                    state_d = S_ACK;
                end else if (w_stop) begin
                    state_d     = S_STOP;
                    stop_pend_d = 1'b0;
                end else if (w_snap) begin
                    state_d        = S_SNAP_W;
                    snap_pend_d    = 1'b0;
                    snap_ret_run_d = 1'b1;
                end else if (!cfg_valid) begin
                    if (w_poll_due) begin
                        state_d = S_POLL_R;
                    end
`ifdef TIMER_HOST_POLL_EN
                    else begin
                        gap_d = gap_q + 8'd1;
                    end
`endif
                end
            end
            S_PROG_STOP:  state_d = S_PROG_PL;
            S_PROG_PL:    state_d = S_PROG_PH;
            S_PROG_PH:    state_d = S_PROG_START;
            S_PROG_START: begin
                state_d   = S_RUN;
                running_d = 1'b1;
            end
            S_ACK: begin
                if (cont_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                    running_d = 1'b0;
                end
            end
            S_STOP: begin
                state_d   = S_IDLE;
                running_d = 1'b0;
            end
            S_SNAP_W:  state_d = S_SNAP_RL;
            S_SNAP_RL: state_d = S_SNAP_LC;
            S_SNAP_LC: begin
                snap_lo_d = tmr.tmr_readdata;
                state_d   = S_SNAP_RH;
            end
            S_SNAP_RH: state_d = S_SNAP_HC;
            S_SNAP_HC: begin
                snap_value_d = {tmr.tmr_readdata, snap_lo_q};
                snap_valid_d = 1'b1;
                state_d      = snap_ret_run_q ? S_RUN : S_IDLE;
            end
            S_POLL_R: state_d = S_POLL_C;
            S_POLL_C: state_d = tmr.tmr_readdata[0] ? S_ACK : S_RUN;
            default:  state_d = S_IDLE;
        endcase

        // A new configuration starts with a stop write, so the timer is no longer running.
        if (w_cfg_accept) begin
            state_d     = S_PROG_STOP;
            period_d    = cfg_period;
            cont_d      = cfg_continuous;
            count_d     = 16'd0;
            running_d   = 1'b0;
            stop_pend_d = 1'b0;
        end

        if (state_d == S_ACK) begin
            tick_d  = 1'b1;
            count_d = count_q + 16'd1;
        end

        // Bus outputs are decoded from the next state so each access lines up with its state.
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'd0;
        case (state_d)
            S_PROG_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_ctrl; wdata_d = c_ctrl_stop;
            end
            S_PROG_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_pl; wdata_d = period_d[15:0];
            end
            S_PROG_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_ph; wdata_d = period_d[31:16];
            end
            S_PROG_START: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_ctrl;
                wdata_d = {12'd0, 1'b0, 1'b1, cont_d, c_ito};
            end
            S_ACK: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_status;
            end
            S_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_ctrl; wdata_d = {15'd0, c_ito};
            end
            S_SNAP_W: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = c_addr_snl;
            end
            S_SNAP_RL: begin
                cs_d = 1'b1; addr_d = c_addr_snl;
            end
            S_SNAP_RH: begin
                cs_d = 1'b1; addr_d = c_addr_snh;
            end
            S_POLL_R: begin
                cs_d = 1'b1; addr_d = c_addr_status;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            period_q       <= 32'd0;
            cont_q         <= 1'b0;
            count_q        <= 16'd0;
            running_q      <= 1'b0;
            tick_q         <= 1'b0;
            snap_valid_q   <= 1'b0;
            snap_value_q   <= 32'd0;
            snap_lo_q      <= 16'd0;
            snap_ret_run_q <= 1'b0;
            stop_pend_q    <= 1'b0;
            snap_pend_q    <= 1'b0;
            addr_q         <= 3'd0;
            cs_q           <= 1'b0;
            wn_q           <= 1'b1;
            wdata_q        <= 16'd0;
`ifdef TIMER_HOST_POLL_EN
            gap_q          <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            cont_q         <= cont_d;
            count_q        <= count_d;
            running_q      <= running_d;
            tick_q         <= tick_d;
            snap_valid_q   <= snap_valid_d;
            snap_value_q   <= snap_value_d;
            snap_lo_q      <= snap_lo_d;
            snap_ret_run_q <= snap_ret_run_d;
            stop_pend_q    <= stop_pend_d;
            snap_pend_q    <= snap_pend_d;
            addr_q         <= addr_d;
            cs_q           <= cs_d;
            wn_q           <= wn_d;
            wdata_q        <= wdata_d;
`ifdef TIMER_HOST_POLL_EN
            gap_q          <= gap_d;
`endif
        end
    end

    assign cfg_ready          = w_cfg_ok;
    assign snap_valid         = snap_valid_q;
    assign snap_value         = snap_value_q;
    assign tick               = tick_q;
    assign timeout_count      = count_q;
    assign running            = running_q;
    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wn_q;
    assign tmr.tmr_writedata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_timer_host_sequencer                                              |
// | Directed bench with a small interval-timer slave model               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_timer_host_sequencer;

    localparam int unsigned POLL_GAP = 4;
`ifdef TIMER_HOST_POLL_EN
    localparam logic [15:0] c_start_mask = 16'hFFFE;
`else
    localparam logic [15:0] c_start_mask = 16'hFFFF;
`endif
    localparam logic [31:0] c_idle = {11'd0, 1'b0, 1'b1, 3'd0, 16'd0};

    typedef struct {
        logic [31:0] period;
        logic        cont;
        logic [15:0] exp_pl;
        logic [15:0] exp_ph;
        logic [15:0] exp_start;
    } prog_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = 32'd0;
    logic        cfg_continuous = 1'b0;
    logic        stop_req = 1'b0;
    logic        snap_req = 1'b0;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic        tick;
    logic [15:0] timeout_count;
    logic        running;

    logic        to_q = 1'b0;
    logic        set_to = 1'b0;
    logic        irq_noise = 1'b0;
    logic [15:0] snap_lo_val = 16'h1234;
    logic [15:0] snap_hi_val = 16'h0005;

    int checks = 0;
    int failures = 0;

    timer_host_sequencer_if bus ();

    timer_host_sequencer #(.POLL_GAP(POLL_GAP)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .stop_req       (stop_req),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .timeout_count  (timeout_count),
        .running        (running),
        .tmr            (bus)
    );

    always #5 clk = ~clk;

    // Slave model: zero-wait writes, reads return data the cycle after the address.
    always_ff @(posedge clk) begin
        if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd0)
            to_q <= 1'b0;
        else if (set_to)
            to_q <= 1'b1;
        if (bus.tmr_chipselect && bus.tmr_write_n) begin
            case (bus.tmr_address)
                3'd0:    bus.tmr_readdata <= {14'd0, 1'b1, to_q};
                3'd4:    bus.tmr_readdata <= snap_lo_val;
                3'd5:    bus.tmr_readdata <= snap_hi_val;
                default: bus.tmr_readdata <= 16'd0;
            endcase
        end else begin
            bus.tmr_readdata <= 16'd0;
        end
    end
    assign bus.tmr_irq = to_q | irq_noise;

    wire [31:0] w_bus = {11'd0, bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata};

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {11'd0, 1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [31:0] rd(input logic [2:0] a);
        return {11'd0, 1'b1, 1'b1, a, 16'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic program_timer(input prog_vec_t v, input string tag);
        @(negedge clk);
        check({tag, " cfg_ready"}, 32'(cfg_ready), 32'd1);
        cfg_period     = v.period;
        cfg_continuous = v.cont;
        cfg_valid      = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check({tag, " stop write"}, w_bus, wr(3'd1, 16'h0008));
        @(negedge clk);
        check({tag, " period low"}, w_bus, wr(3'd2, v.exp_pl));
        @(negedge clk);
        check({tag, " period high"}, w_bus, wr(3'd3, v.exp_ph));
        @(negedge clk);
        check({tag, " start write"}, w_bus, wr(3'd1, v.exp_start & c_start_mask));
        @(negedge clk);
        check({tag, " running"}, 32'(running), 32'd1);
        check({tag, " bus idle"}, w_bus, c_idle);
    endtask

    task automatic service_irq(input string tag, input logic [15:0] exp_count, input logic exp_run);
        @(negedge clk);
        set_to = 1'b1;
        @(negedge clk);
        set_to = 1'b0;
        @(negedge clk);
        check({tag, " ack write"}, w_bus, wr(3'd0, 16'h0000));
        check({tag, " tick"}, 32'(tick), 32'd1);
        check({tag, " count"}, 32'(timeout_count), 32'(exp_count));
        @(negedge clk);
        check({tag, " tick low"}, 32'(tick), 32'd0);
        check({tag, " running"}, 32'(running), 32'(exp_run));
    endtask

`ifdef TIMER_HOST_POLL_EN
    task automatic wait_poll(input logic toggle, output int k, output logic wr_seen);
        k = 99;
        wr_seen = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (toggle) irq_noise = ~irq_noise;
            if (w_bus == rd(3'd0)) begin
                k = i;
                break;
            end
            if (bus.tmr_chipselect && !bus.tmr_write_n) wr_seen = 1'b1;
        end
        irq_noise = 1'b0;
    endtask
`endif

    initial begin
        prog_vec_t vecs[3];
        vecs[0] = '{32'hDEAD_BEEF, 1'b0, 16'hBEEF, 16'hDEAD, 16'h0005};
        vecs[1] = '{32'h0000_0000, 1'b1, 16'h0000, 16'h0000, 16'h0007};
        vecs[2] = '{32'h0001_86A0, 1'b1, 16'h86A0, 16'h0001, 16'h0007};

        repeat (3) @(negedge clk);
        check("reset bus", w_bus, c_idle);
        check("reset cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset running", 32'(running), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset bus", w_bus, c_idle);
        check("post-reset outputs", {running, tick, snap_valid, timeout_count}, 32'd0);
        check("post-reset snap_value", snap_value, 32'd0);

        for (int i = 0; i < 3; i++) begin
            program_timer(vecs[i], $sformatf("prog%0d", i));
        end

`ifdef TIMER_HOST_POLL_EN
        begin
            int   k;
            logic wr_seen;
            wait_poll(1'b1, k, wr_seen);
            check("poll1 interval", 32'(k), 32'(POLL_GAP));
            check("poll1 irq ignored", 32'(wr_seen), 32'd0);
            @(negedge clk);
            set_to = 1'b1;
            check("poll1 capture bus", w_bus, c_idle);
            @(negedge clk);
            set_to = 1'b0;
            check("poll1 no ack", 32'(tick), 32'd0);
            wait_poll(1'b0, k, wr_seen);
            check("poll2 interval", 32'(k), 32'(POLL_GAP));
            @(negedge clk);
            @(negedge clk);
            check("poll2 ack write", w_bus, wr(3'd0, 16'h0000));
            check("poll2 tick", 32'(tick), 32'd1);
            check("poll2 count", 32'(timeout_count), 32'd1);
        end
`else
        for (int i = 1; i <= 3; i++) begin
            service_irq($sformatf("cont irq%0d", i), 16'(i), 1'b1);
        end
        check("cont count", 32'(timeout_count), 32'd3);

        // Snapshot from RUN: write latch, two reads, then a single valid pulse.
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check("snap latch write", w_bus, wr(3'd4, 16'h0000));
        @(negedge clk);
        check("snap read low", w_bus, rd(3'd4));
        @(negedge clk);
        check("snap capture low bus", w_bus, c_idle);
        @(negedge clk);
        check("snap read high", w_bus, rd(3'd5));
        @(negedge clk);
        check("snap valid early", 32'(snap_valid), 32'd0);
        @(negedge clk);
        check("snap valid", 32'(snap_valid), 32'd1);
        check("snap value", snap_value, 32'h0005_1234);
        @(negedge clk);
        check("snap valid pulse", 32'(snap_valid), 32'd0);

        // irq and stop together: the ack wins, the held stop follows.
        set_to = 1'b1;
        @(negedge clk);
        set_to   = 1'b0;
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        check("irq+stop ack write", w_bus, wr(3'd0, 16'h0000));
        check("irq+stop tick", 32'(tick), 32'd1);
        check("irq+stop count", 32'(timeout_count), 32'd4);
        @(negedge clk);
        check("irq+stop back in run", w_bus, c_idle);
        @(negedge clk);
        check("irq+stop stop write", w_bus, wr(3'd1, 16'h0001));
        @(negedge clk);
        check("irq+stop running", 32'(running), 32'd0);
        check("irq+stop cfg_ready", 32'(cfg_ready), 32'd1);

        program_timer('{32'h0000_0010, 1'b0, 16'h0010, 16'h0000, 16'h0005}, "oneshot");
        service_irq("oneshot irq", 16'd1, 1'b0);
        check("oneshot cfg_ready", 32'(cfg_ready), 32'd1);
        check("oneshot bus idle", w_bus, c_idle);

        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle stop noop %0d", i), {cfg_ready, w_bus[30:0]}, {1'b1, c_idle[30:0]});
            @(negedge clk);
        end

        // Reset in the middle of programming abandons the access.
        cfg_period     = 32'h1234_5678;
        cfg_continuous = 1'b1;
        cfg_valid      = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("midreset stop write", w_bus, wr(3'd1, 16'h0008));
        @(negedge clk);
        check("midreset period low", w_bus, wr(3'd2, 16'h5678));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset bus", w_bus, c_idle);
        check("midreset cfg_ready", 32'(cfg_ready), 32'd1);
        check("midreset snap_value", snap_value, 32'd0);
        @(negedge clk);
        check("midreset stays idle", {running, w_bus[30:0]}, {1'b0, c_idle[30:0]});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
